// File: rtl/piso_pkg.sv
// Shared definitions for the parallel-in/serial-out transmitter.
//   state_t   : FSM state encoding (IDLE, SHIFT, GAP)
//   cnt_width : bit-counter width for a given word width
package piso_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    GAP
  } state_t;

  // Counts WIDTH-1 down to 0, so $clog2(WIDTH) bits are enough.
  function automatic int unsigned cnt_width(input int unsigned width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/piso_tx.sv
// Parallel-in/serial-out transmitter.
// Accepts a WIDTH-bit word on a valid/ready handshake and shifts it out one
// bit per clock, followed by GAP idle cycles.
// Ports:
//   clk        : clock, all state changes on the rising edge
//   rst        : synchronous active-high reset
//   din        : parallel word to transmit
//   din_valid  : producer has a word on din
//   din_ready  : word accepted this cycle when din_valid is also high
//   sout       : serial data bit
//   sout_valid : sout carries a frame bit this cycle
//   sout_last  : current bit is the final bit of the frame
//   busy       : a frame or gap is in progress
module piso_tx
  import piso_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned GAP       = 1,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             sout_last,
  output logic             busy
);

  localparam int unsigned     CW       = cnt_width(WIDTH);
  localparam logic [CW-1:0]   CNT_LOAD = CW'(WIDTH - 1);
  localparam logic [3:0]      GAP_LOAD = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

  // The GAP parameter hides the imported enum literal of the same name, so
  // state literals are always written package-scoped.
  state_t           state, state_n;
  logic [WIDTH-1:0] shreg, shreg_n;
  logic [CW-1:0]    bit_cnt, bit_cnt_n;
  logic [3:0]       gap_cnt, gap_cnt_n;
  logic             xfer;
  logic             head_n;

  // Ready in IDLE, or on the last bit of a frame when frames run back-to-back.
  assign din_ready = ~rst & ((state == piso_pkg::IDLE) |
                             ((GAP == 0) & (state == piso_pkg::SHIFT) & (bit_cnt == '0)));
  assign xfer      = din_valid & din_ready;

  always_comb begin
    state_n   = state;
    shreg_n   = shreg;
    bit_cnt_n = bit_cnt;
    gap_cnt_n = gap_cnt;
    case (state)
      piso_pkg::IDLE: begin
        if (xfer) begin
          state_n   = piso_pkg::SHIFT;
          shreg_n   = din;
          bit_cnt_n = CNT_LOAD;
        end
      end
      piso_pkg::SHIFT: begin
        if (bit_cnt == '0) begin
          if (GAP != 0) begin
            state_n   = piso_pkg::GAP;
            gap_cnt_n = GAP_LOAD;
          end else if (xfer) begin
            shreg_n   = din;
            bit_cnt_n = CNT_LOAD;
          end else begin
            state_n = piso_pkg::IDLE;
          end
        end else begin
          shreg_n   = MSB_FIRST ? {shreg[WIDTH-2:0], 1'b0} : {1'b0, shreg[WIDTH-1:1]};
          bit_cnt_n = bit_cnt - 1'b1;
        end
      end
      piso_pkg::GAP: begin
        if (gap_cnt == '0) state_n = piso_pkg::IDLE;
        else               gap_cnt_n = gap_cnt - 1'b1;
      end
      default: state_n = piso_pkg::IDLE;
    endcase
  end

  // Outputs are registered from the next-state values so the bit leaving
  // the register appears in the same cycle the FSM is in SHIFT.
  assign head_n = MSB_FIRST ? shreg_n[WIDTH-1] : shreg_n[0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= piso_pkg::IDLE;
      shreg      <= '0;
      bit_cnt    <= '0;
      gap_cnt    <= '0;
      sout       <= 1'b0;
      sout_valid <= 1'b0;
      sout_last  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_n;
      shreg      <= shreg_n;
      bit_cnt    <= bit_cnt_n;
      gap_cnt    <= gap_cnt_n;
      sout       <= (state_n == piso_pkg::SHIFT) & head_n;
      sout_valid <= (state_n == piso_pkg::SHIFT);
      sout_last  <= (state_n == piso_pkg::SHIFT) & (bit_cnt_n == '0);
      busy       <= (state_n != piso_pkg::IDLE);
    end
  end

endmodule

// File: tb/tb_piso_tx.sv
// Self-checking bench for piso_tx. Three instances cover MSB-first with a
// one-cycle gap (a), LSB-first with a one-cycle gap (b) and MSB-first with
// no gap (c). Expected {last,bit} pairs are queued when a word is accepted
// and checked whenever an instance drives sout_valid.
module tb_piso_tx;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [7:0] a_din = '0, b_din = '0, c_din = '0;
  logic a_valid = 1'b0, b_valid = 1'b0, c_valid = 1'b0;
  logic a_ready, a_sout, a_sv, a_sl, a_busy;
  logic b_ready, b_sout, b_sv, b_sl, b_busy;
  logic c_ready, c_sout, c_sv, c_sl, c_busy;

  piso_tx #(.WIDTH(8), .GAP(1), .MSB_FIRST(1'b1)) u_a (
    .clk(clk), .rst(rst), .din(a_din), .din_valid(a_valid), .din_ready(a_ready),
    .sout(a_sout), .sout_valid(a_sv), .sout_last(a_sl), .busy(a_busy));

  piso_tx #(.WIDTH(8), .GAP(1), .MSB_FIRST(1'b0)) u_b (
    .clk(clk), .rst(rst), .din(b_din), .din_valid(b_valid), .din_ready(b_ready),
    .sout(b_sout), .sout_valid(b_sv), .sout_last(b_sl), .busy(b_busy));

  piso_tx #(.WIDTH(8), .GAP(0), .MSB_FIRST(1'b1)) u_c (
    .clk(clk), .rst(rst), .din(c_din), .din_valid(c_valid), .din_ready(c_ready),
    .sout(c_sout), .sout_valid(c_sv), .sout_last(c_sl), .busy(c_busy));

  int checks = 0;
  int errors = 0;
  logic [1:0] q_a[$], q_b[$], q_c[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Queue one frame of {last,bit} pairs in transmission order.
  task automatic push(input int which, input logic [7:0] w, input bit msb);
    logic [1:0] e;
    for (int i = 0; i < 8; i++) begin
      e = {(i == 7), (msb ? w[7-i] : w[i])};
      case (which)
        0: q_a.push_back(e);
        1: q_b.push_back(e);
        default: q_c.push_back(e);
      endcase
    end
  endtask

  task automatic pop_chk(input int which, input logic [1:0] obs);
    int n;
    logic [1:0] e;
    n = (which == 0) ? q_a.size() : (which == 1) ? q_b.size() : q_c.size();
    chk($sformatf("bit_expected_%0d", which), {31'd0, n > 0}, 32'd1);
    if (n > 0) begin
      case (which)
        0: e = q_a.pop_front();
        1: e = q_b.pop_front();
        default: e = q_c.pop_front();
      endcase
      chk($sformatf("last_bit_%0d", which), {30'd0, obs}, {30'd0, e});
    end
  endtask

  always @(negedge clk) begin
    if (a_sv === 1'b1) pop_chk(0, {a_sl, a_sout});
    if (b_sv === 1'b1) pop_chk(1, {b_sl, b_sout});
    if (c_sv === 1'b1) pop_chk(2, {c_sl, c_sout});
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "simulation time limit");
  end

  initial begin
    bit found;

    // 1. Reset with din_valid high
    a_valid = 1'b1; b_valid = 1'b1; c_valid = 1'b1; a_din = 8'h77;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("rst_ready_a", a_ready, 0);
      chk("rst_ready_c", c_ready, 0);
      chk("rst_outs_a", {a_sout, a_sv, a_sl, a_busy}, 0);
      chk("rst_outs_c", {c_sout, c_sv, c_sl, c_busy}, 0);
    end
    rst = 1'b0; a_valid = 1'b0; b_valid = 1'b0; c_valid = 1'b0;
    #1;
    chk("post_rst_ready_a", a_ready, 1);
    chk("post_rst_ready_b", b_ready, 1);
    tick();
    chk("no_xfer_busy_a", a_busy, 0);
    chk("no_xfer_sv_a", a_sv, 0);

    // 2. MSB first, GAP=1, 8'hA5
    a_din = 8'hA5; a_valid = 1'b1; push(0, 8'hA5, 1'b1);
    tick();
    a_valid = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      chk("a5_sv", a_sv, 1);
      chk("a5_last", a_sl, (k == 8));
      chk("a5_ready", a_ready, 0);
      chk("a5_busy", a_busy, 1);
      if (k < 8) tick();
    end
    tick();
    chk("a5_gap_sv", a_sv, 0);
    chk("a5_gap_busy", a_busy, 1);
    chk("a5_gap_ready", a_ready, 0);
    tick();
    chk("a5_idle_ready", a_ready, 1);
    chk("a5_idle_busy", a_busy, 0);

    // 3. LSB first, 8'h1E
    b_din = 8'h1E; b_valid = 1'b1; push(1, 8'h1E, 1'b0);
    tick();
    b_valid = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      chk("1e_last", b_sl, (k == 8));
      if (k < 8) tick();
    end
    tick(); tick();
    chk("1e_idle_ready", b_ready, 1);

    // 4. GAP=0 back-to-back 8'hFF then 8'h00
    c_din = 8'hFF; c_valid = 1'b1; push(2, 8'hFF, 1'b1);
    tick();
    c_din = 8'h00;
    for (int k = 1; k <= 16; k++) begin
      chk("b2b_sv", c_sv, 1);
      chk("b2b_ready", c_ready, (k % 8 == 0));
      chk("b2b_last", c_sl, (k % 8 == 0));
      if (k == 8) push(2, 8'h00, 1'b1);
      if (k == 9) c_valid = 1'b0;
      if (k < 16) tick();
    end
    tick();
    chk("b2b_end_sv", c_sv, 0);
    chk("b2b_end_ready", c_ready, 1);

    // 5. Pulse 8'h55 during SHIFT of 8'hF0
    a_din = 8'hF0; a_valid = 1'b1; push(0, 8'hF0, 1'b1);
    tick();
    a_valid = 1'b0;
    tick(); tick();
    a_din = 8'h55; a_valid = 1'b1;
    chk("pulse_ready", a_ready, 0);
    tick();
    a_valid = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      found = a_ready;
    end
    chk("f0_ready_wait", found, 1);
    chk("f0_not_captured_busy", a_busy, 0);
    a_valid = 1'b1; push(0, 8'h55, 1'b1);
    tick();
    a_valid = 1'b0;
    for (int i = 0; i < 10; i++) tick();

    // 6. Reset after three bits of 8'hC3, then 8'h3C
    a_din = 8'hC3; a_valid = 1'b1; push(0, 8'hC3, 1'b1);
    tick();
    a_valid = 1'b0;
    tick(); tick();
    rst = 1'b1;
    tick();
    q_a.delete();
    chk("mid_rst_sv", a_sv, 0);
    chk("mid_rst_busy", a_busy, 0);
    chk("mid_rst_ready", a_ready, 0);
    rst = 1'b0;
    tick();
    chk("after_rst_sv", a_sv, 0);
    chk("after_rst_ready", a_ready, 1);
    a_din = 8'h3C; a_valid = 1'b1; push(0, 8'h3C, 1'b1);
    tick();
    a_valid = 1'b0;
    for (int i = 0; i < 10; i++) tick();

    chk("drain_a", q_a.size(), 0);
    chk("drain_b", q_b.size(), 0);
    chk("drain_c", q_c.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/piso_tx.md
# piso_tx

Parallel-in/serial-out transmitter. It accepts a WIDTH-bit word over a valid/ready handshake and shifts it out one bit per clock with a valid strobe and a last-bit marker. It is the transmit end paired with the team's serial-in shift-register receivers in the sequential logic library, and it sits between a word-oriented producer and a single-wire serial link.

## Interface
- WIDTH, 8: word width in bits; legal range is WIDTH ≥ 2.
- GAP, 1: idle cycles inserted after each frame; legal range is 0..15.
- MSB_FIRST, 1: 1 sends bit WIDTH-1 first; 0 sends bit 0 first.
- clk  in  1  single clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- din  in  WIDTH  parallel word to transmit.
- din_valid  in  1  producer has a word on din.
- din_ready  out  1  block can accept a word this cycle.
- sout  out  1  serial data bit.
- sout_valid  out  1  sout carries a frame bit this cycle.
- sout_last  out  1  current bit is the final bit of the frame.
- busy  out  1  a frame or gap is in progress.

## Operation
- FSM states:
  - IDLE: din_ready=1, serial outputs low.
  - SHIFT: WIDTH bit cycles.
  - GAP: GAP cycles with serial outputs low.
- Transfer occurs when din_valid && din_ready are both high at a rising edge. din is then captured into the shift register, the bit counter is loaded with WIDTH-1, and the state goes to SHIFT.
- In SHIFT:
  - sout = shreg[WIDTH-1] when MSB_FIRST=1, otherwise shreg[0].
  - The register shifts toward that end each cycle.
  - The counter decrements each cycle; sout_last=1 when the counter is 0.
- Exit from SHIFT after the last bit:
  - GAP>0: go to GAP, with a gap counter loaded to GAP-1.
  - GAP=0 and a transfer occurs on the last bit cycle: reload and stay in SHIFT (back-to-back frames).
  - GAP=0 and no transfer: go to IDLE.
- GAP returns to IDLE when the gap counter reaches 0.
- din_ready:
  - 1 in IDLE.
  - In SHIFT, 1 only on the last bit cycle and only when GAP=0.
  - 0 in every other state and cycle.
- busy=1 in SHIFT and GAP.
- din_valid while din_ready=0 is ignored. The producer holds din stable until the transfer.
- Bit counter width is $clog2(WIDTH). There is no wrap-around: the counter only ever counts WIDTH-1 down to 0.

## Timing
- Reset values (at the first edge with rst=1 and while rst stays high): sout=0, sout_valid=0, sout_last=0, busy=0, state=IDLE. din_ready is forced to 0 while rst=1.
- First cycle after rst falls: din_ready=1.
- Latency: a transfer at edge N puts the first bit on sout in cycle N+1. The last bit is in cycle N+WIDTH, with sout_last=1 in that cycle.
- Frame period:
  - GAP>0: WIDTH+GAP+1 cycles minimum, including the IDLE acceptance cycle.
  - GAP=0 with back-to-back transfers: exactly WIDTH cycles, and sout_valid stays continuously high.
- Reset mid-frame: the partial word is discarded and no further bits of it appear. All outputs take their reset values at the next edge.
- rst has priority over a simultaneous transfer; the word is not captured.
- All outputs are registered except din_ready, which is decoded from state, counter and rst.

## Structure
- Shared package piso_pkg:
  - The state typedef: enum {IDLE, SHIFT, GAP}.
  - A localparam helper for the counter width.
- No sub-module. The FSM, shift register and the two down-counters live in a single module; each is a few registers.

## Test plan
1. Reset: hold rst=1 for 2 cycles with din_valid=1.
   - Required: din_ready=0, sout/sout_valid/sout_last/busy=0.
   - After rst falls: din_ready=1 and no transfer has occurred.
2. MSB_FIRST=1, GAP=1: send din=8'hA5.
   - Required: sout=1,0,1,0,0,1,0,1 over cycles N+1..N+8, with sout_last only at N+8.
   - Cycle N+9: gap, sout_valid=0.
   - Cycle N+10: din_ready=1.
3. MSB_FIRST=0: send din=8'h1E.
   - Required: sout=0,1,1,1,1,0,0,0, with sout_last on the 8th bit.
4. GAP=0: hold din_valid high with 8'hFF then 8'h00.
   - Required: 16 consecutive sout_valid cycles, sout=eight 1s then eight 0s.
   - din_ready high only on bit 8 of each frame.
5. Pulse din_valid with din=8'h55 during SHIFT of 8'hF0.
   - Required: 8'h55 is not captured until din_ready=1.
   - The 8'hF0 bits are undisturbed.
6. Assert rst for 1 cycle after 3 bits of 8'hC3, then send 8'h3C.
   - Required: sout_valid=0 in the cycle after reset, and no further 8'hC3 bits appear.
   - 8'h3C then transmits as 0,0,1,1,1,1,0,0.
